// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: the CPU passes straight through to the memory port,
// and DMA transfers run a setup/strobe/ack sequence in the gaps between CPU accesses.
module mem_arbiter #(
  parameter int AW         = 13,
  parameter int DW         = 8,
  parameter int STARVE_LIM = 15
)(
  input  logic          clk,
  input  logic          ena,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          dma_starve,
  input  logic          starve_clr,
  output logic [7:0]    abort_cnt,
  output logic          proto_err
);
  typedef enum logic [1:0] {IDLE, DSETUP, DSTROBE, DACK} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t        r_state, w_state_nxt;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata;
  logic [3:0]    r_wait, w_wait_nxt;
  logic          r_starve, r_perr;
  logic [7:0]    r_abort;
  logic          w_busy, w_abort, w_starve_set;

  assign w_busy     = cpu_rd | cpu_wr;
  assign cpu_rdata  = mem_rdata;
  assign dma_gnt    = (r_state == DSETUP) || (r_state == DSTROBE);
  assign dma_ack    = (r_state == DACK);
  assign dma_rdata  = r_rdata;
  assign dma_starve = r_starve;
  assign abort_cnt  = r_abort;
  assign proto_err  = r_perr;

  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    case (r_state)
      IDLE:    if (dma_req && !w_busy) w_state_nxt = DSETUP;
      DSETUP:  begin
        w_state_nxt = w_busy ? IDLE : DSTROBE;
        w_abort     = w_busy;
      end
      DSTROBE: begin
        w_state_nxt = w_busy ? IDLE : DACK;
        w_abort     = w_busy;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // CPU wins the bus outright; a read+write collision drives no strobe at all.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if (w_busy) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_rd    = cpu_rd & ~cpu_wr;
      mem_wr    = cpu_wr & ~cpu_rd;
    end else if (r_state == DSETUP || r_state == DSTROBE) begin
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
      mem_rd    = (r_state == DSTROBE) & ~r_we;
      mem_wr    = (r_state == DSTROBE) & r_we;
    end
  end

  // Wait counter only advances while a request sits in IDLE behind the CPU.
  always_comb begin
    w_wait_nxt = r_wait;
    if (!dma_req)
      w_wait_nxt = '0;
    else if (r_state == IDLE) begin
      if (!w_busy)
        w_wait_nxt = '0;
      else if (r_wait != LIM)
        w_wait_nxt = r_wait + 4'd1;
    end
  end
  assign w_starve_set = (r_wait != LIM) && (w_wait_nxt == LIM);

  always_ff @(posedge clk) begin
    if (!ena) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_wait   <= '0;
      r_starve <= 1'b0;
      r_perr   <= 1'b0;
      r_abort  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_state_nxt == DSETUP) begin
        r_we    <= dma_we;
        r_addr  <= dma_addr;
        r_wdata <= dma_wdata;
      end
      if (r_state == DSTROBE && w_state_nxt == DACK && !r_we)
        r_rdata <= mem_rdata;
      if (w_abort && r_abort != 8'hFF)
        r_abort <= r_abort + 8'd1;
      r_wait <= w_wait_nxt;
      if (w_starve_set)
        r_starve <= 1'b1;
      else if (starve_clr)
        r_starve <= 1'b0;
      if (cpu_rd & cpu_wr)
        r_perr <= 1'b1;
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 13, memory address width.
REQ-002 SHALL have parameter DW, default 8, memory data width.
REQ-003 SHALL have parameter STARVE_LIM, default 15, DMA wait-cycle threshold for starvation flag (4-bit counter).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 ena  in  1  reset; synchronous, active-low (ena=0 at a rising edge resets the block).
REQ-006 cpu_rd  in  1  CPU read strobe from control state machine, level.
REQ-007 cpu_wr  in  1  CPU write strobe, level.
REQ-008 cpu_addr  in  AW  CPU address.
REQ-009 cpu_wdata  in  DW  CPU write data.
REQ-010 cpu_rdata  out  DW  read data to CPU, equals mem_rdata combinationally.
REQ-011 dma_req  in  1  DMA/loader transfer request, level, held until dma_ack.
REQ-012 dma_we  in  1  DMA direction: 1 write, 0 read; sampled with dma_req.
REQ-013 dma_addr  in  AW  DMA address.
REQ-014 dma_wdata  in  DW  DMA write data.
REQ-015 dma_gnt  out  1  high while a DMA transfer is in progress (DSETUP, DSTROBE).
REQ-016 dma_ack  out  1  one-cycle completion pulse.
REQ-017 dma_rdata  out  DW  captured read data, valid with dma_ack, held until next capture.
REQ-018 mem_rd, mem_wr  out  1 each  memory strobes.
REQ-019 mem_addr  out  AW; mem_wdata  out  DW; mem_rdata  in  DW.
REQ-020 dma_starve  out  1  sticky starvation flag; starve_clr  in  1  clears it.
REQ-021 abort_cnt  out  8  saturating count of DMA transfers pre-empted by CPU.
REQ-022 proto_err  out  1  sticky flag: cpu_rd and cpu_wr high together.

Function
REQ-023 cpu_busy = cpu_rd | cpu_wr; CPU SHALL always have absolute priority with zero-cycle latency (combinational path to mem_*), as CPU cannot stall.
REQ-024 FSM states: IDLE, DSETUP, DSTROBE, DACK.
REQ-025 IDLE: if dma_req=1 and cpu_busy=0 -> DSETUP, latching dma_we/addr/wdata into internal registers; else stay.
REQ-026 DSETUP: if cpu_busy=1 -> IDLE (abort); else -> DSTROBE. No strobe driven by DMA.
REQ-027 DSTROBE: DMA strobe (mem_rd if latched we=0, mem_wr if we=1) for exactly this cycle; if cpu_busy=1 -> IDLE (abort, DMA strobe suppressed); else -> DACK, capturing mem_rdata into dma_rdata when read.
REQ-028 DACK: dma_ack=1 for one cycle -> IDLE; back-to-back request sampled next IDLE cycle (min 4 cycles per transfer).
REQ-029 Aborted transfer SHALL be retried automatically from IDLE while dma_req stays high; abort_cnt increments by 1 per abort, saturates at 255.
REQ-030 Output mux: cpu_busy=1 -> mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_rd=cpu_rd, mem_wr=cpu_wr; else DSETUP/DSTROBE -> latched DMA addr/wdata; else mem_addr=0, mem_wdata=0, strobes 0.
REQ-031 cpu_rd=cpu_wr=1: mem_rd=mem_wr=0, mem_addr=cpu_addr, proto_err set next edge; still treated as cpu_busy.
REQ-032 Wait counter: increments each cycle dma_req=1 in IDLE and no grant taken; clears on entering DSETUP or dma_req=0; saturates at STARVE_LIM; reaching STARVE_LIM sets dma_starve.
REQ-033 starve_clr=1 clears dma_starve; simultaneous set and clear -> set wins.
REQ-034 dma_req dropped mid-transfer SHALL NOT abort it; transfer completes with ack.

Reset
REQ-035 ena=0 at a rising edge: state IDLE; dma_gnt, dma_ack, dma_rdata, dma_starve, proto_err, abort_cnt, wait counter, latched DMA regs all 0.
REQ-036 Reset mid-transfer SHALL drop the transfer without dma_ack; CPU passthrough remains combinational during reset.

Verification
REQ-037 DMA write 0x1A5<-0x3C, CPU idle -> gnt cycles 1-2, mem_wr=1 addr 0x1A5 data 0x3C in cycle 2, dma_ack cycle 3.
REQ-038 DMA read 0x0010, mem_rdata=0x77 -> dma_rdata=0x77 with dma_ack, mem_rd one cycle only.
REQ-039 cpu_rd asserted during DSTROBE -> mem_addr=cpu_addr, DMA strobe suppressed, abort_cnt 0->1, retry completes after CPU idle.
REQ-040 CPU busy 20 cycles with dma_req high -> dma_starve=1 after 15 waiting cycles; starve_clr clears it.
REQ-041 cpu_rd=cpu_wr=1 -> both mem strobes 0, proto_err=1 sticky until ena=0.
REQ-042 ena=0 during DSETUP -> no dma_ack, all flags/counters 0 next cycle.
